// File: rtl/gp_pkg.sv
// gp_pkg: shared constants, opcodes and FSM encoding for the graphics processor.
package gp_pkg;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int ADDR_W = 19;
    localparam logic OP_FILL = 1'b0;
    localparam logic OP_OUTLINE = 1'b1;
    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
endpackage

// File: rtl/gp_raster_gen.sv
// gp_raster_gen: raster-order x/y walker with incremental row base and end-of-rectangle flag.
module gp_raster_gen
    import gp_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [9:0]        tl_x,
    input  logic [8:0]        tl_y,
    input  logic [9:0]        br_x,
    input  logic [8:0]        br_y,
    output logic [9:0]        x,
    output logic [8:0]        y,
    output logic [ADDR_W-1:0] row_base,
    output logic              last
);
    assign last = (x == br_x) && (y == br_y);

    // The only multiply happens once at load; rows advance by addition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
            row_base <= '0;
        end else if (load) begin
            x <= tl_x;
            y <= tl_y;
            row_base <= ADDR_W'(tl_y) * ADDR_W'(SCREEN_W);
        end else if (step) begin
            if (x == br_x) begin
                x <= tl_x;
                y <= y + 9'd1;
                row_base <= row_base + ADDR_W'(SCREEN_W);
            end else begin
                x <= x + 10'd1;
            end
        end
    end
endmodule

// File: rtl/graphics_processor.sv
// graphics_processor: rectangle fill/outline engine writing RGB444 pixels to a linear framebuffer.
// Define GP_OUTLINE_EN to enable the 1-pixel outline opcode; otherwise opcode 1 fills.
module graphics_processor
    import gp_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gp_en,
    input  logic              gp_opcode,
    input  logic [9:0]        gp_tl_x,
    input  logic [8:0]        gp_tl_y,
    input  logic [9:0]        gp_br_x,
    input  logic [8:0]        gp_br_y,
    input  logic [11:0]       gp_arg,
    output logic              gp_finish,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [11:0]       vram_data
);
    state_t state;
    logic [9:0] tl_x, br_x, cbr_x, x;
    logic [8:0] tl_y, br_y, cbr_y, y;
    logic [11:0] colour;
    logic [ADDR_W-1:0] row_base;
    logic last, pix_we;

    assign cbr_x = (br_x > 10'(SCREEN_W - 1)) ? 10'(SCREEN_W - 1) : br_x;
    assign cbr_y = (br_y > 9'(SCREEN_H - 1)) ? 9'(SCREEN_H - 1) : br_y;

    gp_raster_gen #(.SCREEN_W(SCREEN_W)) u_raster (
        .clk(clk),
        .rst(rst),
        .load(state == SETUP),
        .step(state == DRAW),
        .tl_x(tl_x),
        .tl_y(tl_y),
        .br_x(cbr_x),
        .br_y(cbr_y),
        .x(x),
        .y(y),
        .row_base(row_base),
        .last(last)
    );

`ifdef GP_OUTLINE_EN
    logic op;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op <= OP_FILL;
        else if (state == IDLE && gp_en && !gp_finish)
            op <= gp_opcode;
    end
    assign pix_we = (op == OP_FILL) || x == tl_x || x == cbr_x || y == tl_y || y == cbr_y;
`else
    logic unused_opcode;
    assign unused_opcode = gp_opcode;
    assign pix_we = 1'b1;
`endif

    // The finish pulse is still visible in the first IDLE cycle; a request held
    // until the initiator samples it must not be taken as a new command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gp_finish <= 1'b0;
            vram_we <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
            tl_x <= '0;
            tl_y <= '0;
            br_x <= '0;
            br_y <= '0;
            colour <= '0;
        end else begin
            gp_finish <= 1'b0;
            vram_we <= 1'b0;
            case (state)
                IDLE: if (gp_en && !gp_finish) begin
                    tl_x <= gp_tl_x;
                    tl_y <= gp_tl_y;
                    br_x <= gp_br_x;
                    br_y <= gp_br_y;
                    colour <= gp_arg;
                    state <= SETUP;
                end
                SETUP: state <= (tl_x > cbr_x || tl_y > cbr_y) ? DONE : DRAW;
                DRAW: begin
                    vram_we <= pix_we;
                    vram_addr <= row_base + ADDR_W'(x);
                    vram_data <= colour;
                    if (last)
                        state <= DONE;
                end
                DONE: begin
                    gp_finish <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
